// File: rtl/uart_rx_os8.sv
// uart_rx_os8: 8x-oversampled 8N1 UART receiver.
// Recovers frames from an idle-high serial line using the bclk_x8 enable and
// presents each byte plus its raw frame on a valid/ack holding register.
module uart_rx_os8 #(
  parameter int OSR   = 8,
  parameter int DBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_x8,
  input  logic             rx,
  input  logic             rx_ack,
  output logic [DBITS-1:0] rx_data,
  output logic [DBITS+1:0] rx_frame,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);
  localparam int TCW = $clog2(OSR);
  localparam int BIW = $clog2(DBITS);
  localparam logic [TCW-1:0] TC_MID  = TCW'(OSR / 2 - 1);
  localparam logic [TCW-1:0] TC_LAST = TCW'(OSR - 1);
  localparam logic [BIW-1:0] BI_LAST = BIW'(DBITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [TCW-1:0]   tc, tc_n;
  logic [BIW-1:0]   bi, bi_n;
  logic [DBITS-1:0] shift;
  logic             sync1, rxs;
  logic             samp, load;

  // Two-flop synchronizer; both stages idle high so reset looks like a quiet line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  // Next-state logic: everything advances only on oversampling ticks.
  // START checks mid-bit (4th tick after detection) to reject glitches;
  // DATA/STOP sample on the last tick of each 8-tick bit cell, which lands mid-bit.
  always_comb begin
    state_n = state;
    tc_n    = tc;
    bi_n    = bi;
    samp    = 1'b0;
    load    = 1'b0;
    if (tick_x8) begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state_n = START;
            tc_n    = '0;
          end
        end
        START: begin
          if (tc == TC_MID) begin
            if (rxs) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              tc_n    = '0;
              bi_n    = '0;
            end
          end else begin
            tc_n = tc + 1'b1;
          end
        end
        DATA: begin
          tc_n = tc + 1'b1;
          if (tc == TC_LAST) begin
            samp = 1'b1;
            bi_n = bi + 1'b1;
            if (bi == BI_LAST) state_n = STOP;
          end
        end
        STOP: begin
          tc_n = tc + 1'b1;
          if (tc == TC_LAST) begin
            load    = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // FSM state, counters, data shift register and registered busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      tc    <= '0;
      bi    <= '0;
      shift <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      tc    <= tc_n;
      bi    <= bi_n;
      busy  <= (state_n != IDLE);
      if (samp) shift[bi] <= rxs;
    end
  end

  // Holding register: a load into a full, unacked register is dropped and
  // flagged as overrun; load coincident with ack replaces the held frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data   <= '0;
      rx_frame  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (load) begin
      if (rx_valid && !rx_ack) begin
        overrun <= 1'b1;
      end else begin
        rx_data   <= shift;
        rx_frame  <= {rxs, shift, 1'b0};
        frame_err <= ~rxs;
        rx_valid  <= 1'b1;
      end
    end else if (rx_valid && rx_ack) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule
